// File: rtl/jt51_wrq.sv
// Register-write queue for a JT51-style synthesizer: buffers {addr,data} pairs and
// replays each one as an address strobe, a gap, a data strobe, then waits for busy to drop.
module jt51_wrq #(
  parameter int DEPTH   = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen_p1,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_addr,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  output logic                     cs_n,
  output logic                     wr_n,
  output logic                     a0,
  output logic [7:0]               din,
  input  logic                     busy_in,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle,
  output logic                     tmo_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_GAP1   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_WAITB  = 3'd5;

  // fsm_state is the observable FSM state for checkers
  logic [2:0]    fsm_state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    hold_data;
  logic [SW-1:0] set_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          push;
  logic          pop;
  logic          strobe;

  // Host handshake: a write transfers on a rising clk edge where wr_valid and wr_ready
  // are both high; wr_ready depends only on level, so a same-cycle pop cannot unblock it.
  assign wr_ready = (level < LVL_FULL);
  assign push     = wr_valid && wr_ready && !flush;
  assign pop      = (fsm_state == ST_IDLE) && (level != '0) && !flush;
  assign strobe   = (fsm_state == ST_ADDR) || (fsm_state == ST_DATA);
  assign cs_n     = ~strobe;
  assign wr_n     = ~strobe;
  assign idle     = (level == '0) && (fsm_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // din/a0 are loaded on entry to each strobe state and otherwise hold their value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= ST_IDLE;
      hold_data <= '0;
      din       <= '0;
      a0        <= 1'b0;
      set_cnt   <= '0;
      tmo_cnt   <= '0;
      tmo_err   <= 1'b0;
    end else begin
      case (fsm_state)
        ST_IDLE: begin
          if (pop) begin
            din       <= mem[rd_ptr][15:8];
            hold_data <= mem[rd_ptr][7:0];
            a0        <= 1'b0;
            fsm_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (cen_p1) fsm_state <= ST_GAP1;
        end
        ST_GAP1: begin
          din       <= hold_data;
          a0        <= 1'b1;
          fsm_state <= ST_DATA;
        end
        ST_DATA: begin
          if (cen_p1) begin
            set_cnt   <= '0;
            fsm_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (set_cnt == SET_LAST) begin
            tmo_cnt   <= '0;
            fsm_state <= ST_WAITB;
          end else begin
            set_cnt <= set_cnt + SW'(1);
          end
        end
        ST_WAITB: begin
          if (!busy_in) begin
            fsm_state <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_err   <= 1'b1;
            fsm_state <= ST_IDLE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: fsm_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_wrq.sv
// Directed bench for jt51_wrq: bus monitor feeds a scoreboard of expected {addr,data}
// pairs; each directed step checks outputs with immediate assertions.
module tb_jt51_wrq;

  localparam int DEPTH   = 8;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen_p1 = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;
  logic       busy_in = 1'b0;
  logic [3:0] level;
  logic       idle;
  logic       tmo_err;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          cen_mode = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  mon_addr = 8'h00;
  logic [15:0] mon_exp;

  jt51_wrq #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen_p1   (cen_p1),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .flush    (flush),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .a0       (a0),
    .din      (din),
    .busy_in  (busy_in),
    .level    (level),
    .idle     (idle),
    .tmo_err  (tmo_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cen_mode: 0 = hold (manual), 1 = every 2nd cycle, 2 = every cycle
  task automatic tick();
    @(posedge clk);
    #1;
    if (cen_mode == 1)      cen_p1 = ~cen_p1;
    else if (cen_mode == 2) cen_p1 = 1'b1;
    else                    cen_p1 = 1'b0;
  endtask

  task automatic wait_cs(input logic v, input string tag);
    int n = 0;
    while (cs_n !== v && n < 300) begin
      tick();
      n++;
    end
    chk(tag, cs_n, v);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (idle !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, idle, 1);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int   n = 0;
    logic acc = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!acc && n < 500) begin
      acc = wr_ready;
      tick();
      n++;
    end
    wr_valid = 1'b0;
    chk("push_accept", acc, 1);
    if (acc) exp_q.push_back({a, d});
  endtask

  // bus monitor: the synthesizer latches a strobe on a cen_p1 cycle
  always @(negedge clk) begin
    if (rst_n && !cs_n && !wr_n && cen_p1) begin
      if (!a0) begin
        mon_addr = din;
      end else if (exp_q.size() == 0) begin
        chk("bus_unexpected_write", exp_q.size(), 1);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("bus_pair", {mon_addr, din}, mon_exp);
      end
    end
  end

  initial begin
    int bad;
    int n;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_a0", a0, 0);
    chk("rst_din", din, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_tmo_err", tmo_err, 0);
    rst_n = 1'b1;

    // single write, cen every 2nd cycle, busy held after settle
    cen_mode = 1;
    busy_in  = 1'b1;
    push(8'h20, 8'hC7);
    wait_cs(0, "t1_addr_strobe");
    chk("t1_addr_wr_n", wr_n, 0);
    chk("t1_addr_a0", a0, 0);
    chk("t1_addr_din", din, 8'h20);
    wait_cs(1, "t1_gap_cs_n");
    chk("t1_gap_wr_n", wr_n, 1);
    tick();
    chk("t1_data_cs_n", cs_n, 0);
    chk("t1_data_a0", a0, 1);
    chk("t1_data_din", din, 8'hC7);
    wait_cs(1, "t1_data_release");
    chk("t1_hold_din", din, 8'hC7);
    chk("t1_hold_a0", a0, 1);
    repeat (SETTLE + 10) tick();
    chk("t1_busy_idle", idle, 0);
    busy_in = 1'b0;
    tick();
    chk("t1_idle_after_busy", idle, 1);
    chk("t1_tmo_err", tmo_err, 0);
    chk("t1_queue", exp_q.size(), 0);

    // busy stuck high: timeout
    cen_mode = 2;
    busy_in  = 1'b1;
    push(8'hAA, 8'h55);
    wait_cs(0, "t3_addr");
    wait_cs(1, "t3_gap");
    wait_cs(0, "t3_data");
    wait_cs(1, "t3_settle");
    chk("t3_tmo_before", tmo_err, 0);
    n = 0;
    while (idle !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("t3_exit_cycles", n, SETTLE + TIMEOUT);
    chk("t3_tmo_set", tmo_err, 1);
    busy_in = 1'b0;
    push(8'h5A, 8'hA5);
    wait_idle("t3_next_idle");
    chk("t3_tmo_sticky", tmo_err, 1);
    chk("t3_queue", exp_q.size(), 0);

    // fill the FIFO while the FSM is stalled in ADDR
    cen_mode = 0;
    cen_p1   = 1'b0;
    push(8'h01, 8'h80);
    wait_cs(0, "t2_stall_addr");
    for (int i = 1; i <= 8; i++) push(8'(i + 1), 8'(8'h80 + i));
    chk("t2_full_level", level, 8);
    chk("t2_full_ready", wr_ready, 0);
    wr_valid = 1'b1;
    wr_addr  = 8'h0A;
    wr_data  = 8'h89;
    repeat (3) tick();
    chk("t2_stall_level", level, 8);
    chk("t2_stall_ready", wr_ready, 0);
    cen_mode = 2;
    push(8'h0A, 8'h89);
    chk("t2_refill_level", level, 8);
    wait_idle("t2_drain");
    chk("t2_queue", exp_q.size(), 0);
    chk("t2_level_empty", level, 0);

    // flush during the data phase of the first entry
    cen_mode = 0;
    cen_p1   = 1'b0;
    push(8'h30, 8'h31);
    push(8'h40, 8'h41);
    push(8'h50, 8'h51);
    chk("t4_level", level, 2);
    chk("t4_in_addr", cs_n, 0);
    cen_p1 = 1'b1;
    tick();
    chk("t4_gap", cs_n, 1);
    tick();
    chk("t4_data_cs_n", cs_n, 0);
    chk("t4_data_a0", a0, 1);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 8'h60;
    wr_data  = 8'h61;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    chk("t4_flush_level", level, 0);
    chk("t4_entry_kept", cs_n, 0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    cen_mode = 2;
    wait_idle("t4_idle");
    chk("t4_queue", exp_q.size(), 0);
    repeat (12) tick();
    chk("t4_bus_quiet", cs_n, 1);

    // cen held low for 20 cycles in ADDR
    cen_mode = 0;
    cen_p1   = 1'b0;
    push(8'h70, 8'h71);
    wait_cs(0, "t5_addr");
    bad = 0;
    repeat (20) begin
      tick();
      if (cs_n !== 1'b0 || wr_n !== 1'b0) bad++;
    end
    chk("t5_strobe_held", bad, 0);
    cen_p1 = 1'b1;
    chk("t5_cen_cycle", cs_n, 0);
    tick();
    chk("t5_released", cs_n, 1);
    cen_mode = 2;
    wait_idle("t5_idle");
    chk("t5_queue", exp_q.size(), 0);

    // asynchronous reset mid address strobe
    cen_mode = 0;
    cen_p1   = 1'b0;
    push(8'h80, 8'h81);
    push(8'h90, 8'h91);
    wait_cs(0, "t6_addr");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cs_n", cs_n, 1);
    chk("t6_wr_n", wr_n, 1);
    chk("t6_level", level, 0);
    chk("t6_idle", idle, 1);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_a0", a0, 0);
    chk("t6_din", din, 8'h00);
    chk("t6_tmo_err", tmo_err, 0);
    exp_q.delete();
    tick();
    rst_n    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 8'hA0;
    wr_data  = 8'hA1;
    chk("t6_ready_first", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    chk("t6_first_push", level, 1);
    exp_q.push_back({8'hA0, 8'hA1});
    cen_mode = 2;
    wait_idle("t6_idle_end");
    chk("t6_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
